uart_arbiter: RTL and testbench

UART_ARBITER -- requirements
Module: uart_arbiter

---
 rtl/uart_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_arbiter.sv
// -----------------------------------------------------------------------------
// uart_arbiter
//
// Shares one UART core between CPU_N CPU ports. A CPU becomes owner by
// strobing rd/wr; while it owns the UART its strobes, address and write data
// are passed straight through, and the UART read data is returned on its
// slice only. Every other requester is stalled until it is granted.
// Ownership ends on the owner's one-cycle release pulse (or on reset).
// Arbitration is round-robin, starting after the most recent owner.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN):
//   When defined, an idle counter forces a release once the owner has not
//   strobed for TIMEOUT consecutive owned cycles. When undefined, TIMEOUT and
//   TO_W have no effect.
//
// Ports:
//   clk            in   clock, all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   uart_dout      in   [DATA_W]        read data from UART core
//   uart_rd        out  1               read strobe to UART core
//   uart_wr        out  1               write strobe to UART core
//   uart_addr      out  1               address to UART core
//   uart_din       out  [DATA_W]        write data to UART core
//   cpu_uart_dat_o in   [CPU_N*DATA_W]  per-CPU write data (CPU k at k*DATA_W)
//   cpu_uart_rd_o  in   [CPU_N]         per-CPU read strobe
//   cpu_uart_wr_o  in   [CPU_N]         per-CPU write strobe
//   cpu_uart_adr_o in   [CPU_N]         per-CPU address
//   cpu_uart_rel   in   [CPU_N]         per-CPU ownership release pulse
//   cpu_uart_dat_i out  [CPU_N*DATA_W]  per-CPU read data
//   cpu_uart_gnt   out  [CPU_N]         registered one-hot ownership
//   cpu_uart_stall out  [CPU_N]         request & ~grant
// -----------------------------------------------------------------------------
module uart_arbiter #(
    parameter int CPU_N   = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         uart_dout,
    output logic                      uart_rd,
    output logic                      uart_wr,
    output logic                      uart_addr,
    output logic [DATA_W-1:0]         uart_din,
    input  logic [CPU_N*DATA_W-1:0]   cpu_uart_dat_o,
    input  logic [CPU_N-1:0]          cpu_uart_rd_o,
    input  logic [CPU_N-1:0]          cpu_uart_wr_o,
    input  logic [CPU_N-1:0]          cpu_uart_adr_o,
    input  logic [CPU_N-1:0]          cpu_uart_rel,
    output logic [CPU_N*DATA_W-1:0]   cpu_uart_dat_i,
    output logic [CPU_N-1:0]          cpu_uart_gnt,
    output logic [CPU_N-1:0]          cpu_uart_stall
);

    localparam int IDX_W = $clog2(CPU_N);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e               state_q;
    logic [CPU_N-1:0]     gnt_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     last_q;

    logic [CPU_N-1:0]     req;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [CPU_N-1:0]     gnt_d;
    logic                 owner_req;
    logic                 owner_rel;
    logic                 timeout_hit;

    assign req = cpu_uart_rd_o | cpu_uart_wr_o;

    // Round-robin pick: first requester at (last+1), (last+2), ... with wrap,
    // so the most recent owner is considered last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= CPU_N; i++) begin
            cand = IDX_W'((int'(last_q) + i) % CPU_N);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign gnt_d     = CPU_N'(1) << pick_idx;
    assign owner_req = req[owner_q];
    assign owner_rel = cpu_uart_rel[owner_q];

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt_q;
    assign timeout_hit = (idle_cnt_q == TO_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT/TO_W only matter with the idle counter; keep them referenced.
    if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_timeout_cfg_unused
    end
`endif

    // Ownership FSM; grant and owner index are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(CPU_N - 1);   // CPU 0 wins the first arbitration
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= OWNED;
                        gnt_q   <= gnt_d;
                        owner_q <= pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                OWNED: begin
                    // Releases always pass through IDLE; no direct handover.
                    if (owner_rel || timeout_hit) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        last_q  <= owner_q;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end else begin
`ifdef UART_ARB_TIMEOUT_EN
                        if (owner_req) begin
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Owner's bus is forwarded combinationally; everything is zero in IDLE.
    always_comb begin
        uart_rd   = 1'b0;
        uart_wr   = 1'b0;
        uart_addr = 1'b0;
        uart_din  = '0;
        if (state_q == OWNED) begin
            uart_rd   = cpu_uart_rd_o[owner_q];
            uart_wr   = cpu_uart_wr_o[owner_q];
            uart_addr = cpu_uart_adr_o[owner_q];
            uart_din  = cpu_uart_dat_o[owner_q*DATA_W +: DATA_W];
        end
    end

    // owner_req is only consumed by the idle counter.
    logic unused_owner_req;
    assign unused_owner_req = owner_req;

    genvar gi;
    generate
        for (gi = 0; gi < CPU_N; gi++) begin : g_cpu
            assign cpu_uart_dat_i[gi*DATA_W +: DATA_W] = gnt_q[gi] ? uart_dout : '0;
        end
    endgenerate

    assign cpu_uart_gnt   = gnt_q;
    assign cpu_uart_stall = req & ~gnt_q;

endmodule

// File: tb/tb_uart_arbiter.sv
module tb_uart_arbiter;

    localparam int CPU_N   = 3;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 8;

    logic                    clk;
    logic                    rst;
    logic [DATA_W-1:0]       uart_dout;
    logic                    uart_rd;
    logic                    uart_wr;
    logic                    uart_addr;
    logic [DATA_W-1:0]       uart_din;
    logic [CPU_N*DATA_W-1:0] cpu_uart_dat_o;
    logic [CPU_N-1:0]        cpu_uart_rd_o;
    logic [CPU_N-1:0]        cpu_uart_wr_o;
    logic [CPU_N-1:0]        cpu_uart_adr_o;
    logic [CPU_N-1:0]        cpu_uart_rel;
    logic [CPU_N*DATA_W-1:0] cpu_uart_dat_i;
    logic [CPU_N-1:0]        cpu_uart_gnt;
    logic [CPU_N-1:0]        cpu_uart_stall;

    int passed = 0;
    int total  = 0;

    uart_arbiter #(
        .CPU_N  (CPU_N),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_dout     (uart_dout),
        .uart_rd       (uart_rd),
        .uart_wr       (uart_wr),
        .uart_addr     (uart_addr),
        .uart_din      (uart_din),
        .cpu_uart_dat_o(cpu_uart_dat_o),
        .cpu_uart_rd_o (cpu_uart_rd_o),
        .cpu_uart_wr_o (cpu_uart_wr_o),
        .cpu_uart_adr_o(cpu_uart_adr_o),
        .cpu_uart_rel  (cpu_uart_rel),
        .cpu_uart_dat_i(cpu_uart_dat_i),
        .cpu_uart_gnt  (cpu_uart_gnt),
        .cpu_uart_stall(cpu_uart_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock, then sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        uart_dout      = 8'hFF;
        cpu_uart_dat_o = {8'hC3, 8'h41, 8'h10};
        cpu_uart_rd_o  = '0;
        cpu_uart_wr_o  = '0;
        cpu_uart_adr_o = '0;
        cpu_uart_rel   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt",    32'(cpu_uart_gnt), 32'h0);
        chk("rst_uart_wr", 32'(uart_wr), 32'h0);
        chk("rst_uart_rd", 32'(uart_rd), 32'h0);
        chk("rst_din",    32'(uart_din), 32'h0);
        chk("rst_dat_i",  32'(cpu_uart_dat_i), 32'h0);
        rst = 1'b0;

        // CPU1 write from IDLE: one stall cycle, then forwarded
        cpu_uart_wr_o = 3'b010;
        #1;
        chk("c1_stall",   32'(cpu_uart_stall), 32'h2);
        chk("c1_uart_wr", 32'(uart_wr), 32'h0);
        tick();
        chk("c2_gnt",     32'(cpu_uart_gnt), 32'h2);
        chk("c2_uart_wr", 32'(uart_wr), 32'h1);
        chk("c2_din",     32'(uart_din), 32'h41);
        chk("c2_stall",   32'(cpu_uart_stall), 32'h0);

        // CPU1 reads while CPU0 is blocked
        cpu_uart_wr_o  = 3'b001;
        cpu_uart_rd_o  = 3'b010;
        cpu_uart_adr_o = 3'b010;
        uart_dout      = 8'h5A;
        #1;
        chk("rd_dat_i",   32'(cpu_uart_dat_i), 32'h005A00);
        chk("rd_stall",   32'(cpu_uart_stall), 32'h1);
        chk("rd_uart_wr", 32'(uart_wr), 32'h0);
        chk("rd_uart_rd", 32'(uart_rd), 32'h1);
        chk("rd_addr",    32'(uart_addr), 32'h1);

        // CPU1 writes and releases in the same cycle; CPUs 0 and 2 waiting
        tick();
        cpu_uart_rd_o  = '0;
        cpu_uart_adr_o = '0;
        cpu_uart_wr_o  = 3'b111;
        cpu_uart_rel   = 3'b010;
        #1;
        chk("rel_fwd_wr",  32'(uart_wr), 32'h1);
        chk("rel_fwd_din", 32'(uart_din), 32'h41);
        tick();
        cpu_uart_rel  = '0;
        cpu_uart_wr_o = 3'b101;
        #1;
        chk("rel_idle_gnt",   32'(cpu_uart_gnt), 32'h0);
        chk("rel_idle_stall", 32'(cpu_uart_stall), 32'h5);
        chk("rel_idle_wr",    32'(uart_wr), 32'h0);
        tick();
        chk("rr_gnt_cpu2", 32'(cpu_uart_gnt), 32'h4);
        chk("rr_din_cpu2", 32'(uart_din), 32'hC3);
        chk("rr_dat_i",    32'(cpu_uart_dat_i), 32'h5A0000);

        // Release from a non-owner is ignored
        cpu_uart_rel = 3'b001;
        tick();
        cpu_uart_rel = '0;
        chk("nonown_rel_gnt", 32'(cpu_uart_gnt), 32'h4);

        // CPU2 releases; CPU0 is next
        cpu_uart_rel  = 3'b100;
        cpu_uart_wr_o = 3'b001;
        tick();
        cpu_uart_rel = '0;
        chk("c2_rel_gnt", 32'(cpu_uart_gnt), 32'h0);
        tick();
        chk("rr_gnt_cpu0", 32'(cpu_uart_gnt), 32'h1);
        chk("cpu0_din",    32'(uart_din), 32'h10);
        cpu_uart_wr_o = '0;

`ifdef UART_ARB_TIMEOUT_EN
        // Silent owner: 16 cycles still owned, released one cycle after the count hits 16
        for (int i = 0; i < TIMEOUT; i++) tick();
        chk("to_still_owned", 32'(cpu_uart_gnt), 32'h1);
        tick();
        chk("to_released", 32'(cpu_uart_gnt), 32'h0);
`else
        // Without the idle counter, a silent owner keeps the UART
        for (int i = 0; i < 100; i++) tick();
        chk("no_to_gnt", 32'(cpu_uart_gnt), 32'h1);
        cpu_uart_rel = 3'b001;
        tick();
        cpu_uart_rel = '0;
        chk("c0_rel_gnt", 32'(cpu_uart_gnt), 32'h0);
`endif

        // CPU2 takes ownership (last owner was CPU0), then reset mid-ownership
        cpu_uart_wr_o = 3'b100;
        tick();
        chk("c2_own_gnt", 32'(cpu_uart_gnt), 32'h4);
        chk("c2_own_wr",  32'(uart_wr), 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt",   32'(cpu_uart_gnt), 32'h0);
        chk("mid_rst_wr",    32'(uart_wr), 32'h0);
        chk("mid_rst_stall", 32'(cpu_uart_stall), 32'h4);
        rst = 1'b0;
        cpu_uart_wr_o = 3'b101;
        tick();
        chk("post_rst_gnt", 32'(cpu_uart_gnt), 32'h1);
        chk("post_rst_din", 32'(uart_din), 32'h10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
